// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control path.
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESC_W_DEF    = 6;

    localparam int PRESC_X8  = 8;
    localparam int PRESC_X16 = 16;
    localparam int PRESC_X32 = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        EVAL
    } rx_state_t;

endpackage

// File: rtl/uart_rx_err_stats.sv
// Saturating error/glitch event counters for the UART receiver (UART_RX_ERR_STATS_EN builds only).
module uart_rx_err_stats (
    input  logic       CLK,
    input  logic       RST,
    input  logic       par_evt,
    input  logic       stp_evt,
    input  logic       glitch_evt,
    output logic [7:0] par_err_cnt,
    output logic [7:0] stp_err_cnt,
    output logic [7:0] glitch_cnt
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
            glitch_cnt  <= '0;
        end else begin
            if (par_evt)    par_err_cnt <= sat_inc(par_err_cnt);
            if (stp_evt)    stp_err_cnt <= sat_inc(stp_err_cnt);
            if (glitch_evt) glitch_cnt  <= sat_inc(glitch_cnt);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver frame-sequencing FSM: start detection, per-bit strobes, frame qualification.
// Optional error statistics counters with `define UART_RX_ERR_STATS_EN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESC_W    = PRESC_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [3:0]         bit_count,
    input  logic [PRESC_W-1:0] edge_count,
    input  logic               strt_glitch,
    input  logic               par_err_in,
    input  logic               stp_err_in,
    output logic               cnt_en,
    output logic               dat_samp_en,
    output logic               deser_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err
`ifdef UART_RX_ERR_STATS_EN
    ,
    output logic [7:0]         par_err_cnt,
    output logic [7:0]         stp_err_cnt,
    output logic [7:0]         glitch_cnt
`endif
);

    rx_state_t          state;
    logic               par_en_lat;
    logic               par_sticky;
    logic [PRESC_W-1:0] chk_pre;
    logic [PRESC_W-1:0] end_edge;
    logic               at_chk_next;
    logic               at_end;

    // Strobes are registered, so they are armed one edge before CHK while the counter runs.
    assign chk_pre     = (prescale >> 1) + PRESC_W'(1);
    assign end_edge    = prescale - PRESC_W'(1);
    assign at_chk_next = (edge_count == chk_pre);
    assign at_end      = (edge_count == end_edge);
    assign dat_samp_en = cnt_en;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cnt_en      <= 1'b0;
            deser_en    <= 1'b0;
            strt_chk_en <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            par_en_lat  <= 1'b0;
            par_sticky  <= 1'b0;
        end else begin
            deser_en    <= 1'b0;
            strt_chk_en <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state      <= START;
                        cnt_en     <= 1'b1;
                        par_en_lat <= PAR_EN;
                        par_sticky <= 1'b0;
                    end
                end
                START: begin
                    if (strt_chk_en && strt_glitch) begin
                        state  <= IDLE;
                        cnt_en <= 1'b0;
                    end else begin
                        strt_chk_en <= at_chk_next;
                        if (at_end) state <= DATA;
                    end
                end
                DATA: begin
                    deser_en <= at_chk_next;
                    if (at_end && bit_count == 4'(DATA_WIDTH))
                        state <= par_en_lat ? PARITY : STOP;
                end
                PARITY: begin
                    par_chk_en <= at_chk_next;
                    if (par_chk_en && par_err_in) par_sticky <= 1'b1;
                    if (at_end) state <= STOP;
                end
                STOP: begin
                    // Verdict is registered here so it is visible in the EVAL cycle.
                    stp_chk_en <= at_chk_next;
                    if (stp_chk_en) begin
                        par_err    <= par_sticky;
                        stp_err    <= stp_err_in;
                        data_valid <= !par_sticky && !stp_err_in;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    state  <= IDLE;
                    cnt_en <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cnt_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_ERR_STATS_EN
    uart_rx_err_stats u_stats (
        .CLK         (CLK),
        .RST         (RST),
        .par_evt     (state == EVAL && par_err),
        .stp_evt     (state == EVAL && stp_err),
        .glitch_evt  (state == START && strt_chk_en && strt_glitch),
        .par_err_cnt (par_err_cnt),
        .stp_err_cnt (stp_err_cnt),
        .glitch_cnt  (glitch_cnt)
    );
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized frame-schedule bench for uart_rx_ctrl with an environment edge/bit counter.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int DW   = 8;
    localparam int PW   = 6;
    localparam int MAXC = 24000;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN, PAR_EN;
    logic [PW-1:0] prescale;
    logic [3:0]    bit_count;
    logic [PW-1:0] edge_count;
    logic          strt_glitch, par_err_in, stp_err_in;
    logic          cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic          data_valid, par_err, stp_err;
`ifdef UART_RX_ERR_STATS_EN
    logic [7:0]    par_err_cnt, stp_err_cnt, glitch_cnt;
`endif

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
        .bit_count(bit_count), .edge_count(edge_count), .strt_glitch(strt_glitch),
        .par_err_in(par_err_in), .stp_err_in(stp_err_in), .cnt_en(cnt_en),
        .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err)
`ifdef UART_RX_ERR_STATS_EN
        , .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt), .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Environment: the edge/bit counter the FSM enables.
    always @(posedge CLK or posedge RST) begin
        if (RST || !cnt_en) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (edge_count == prescale - PW'(1)) begin
            edge_count <= '0;
            bit_count  <= bit_count + 4'd1;
        end else begin
            edge_count <= edge_count + PW'(1);
        end
    end

    // Per-cycle plan: stimulus and expected outputs.
    logic rx_a [0:MAXC-1];
    logic pen_a[0:MAXC-1];
    logic gl_a [0:MAXC-1];
    logic pe_a [0:MAXC-1];
    logic se_a [0:MAXC-1];
    logic rst_a[0:MAXC-1];
    int   pre_a[0:MAXC-1];
    logic cnt_x[0:MAXC-1];
    logic des_x[0:MAXC-1];
    logic sc_x [0:MAXC-1];
    logic pc_x [0:MAXC-1];
    logic tc_x [0:MAXC-1];
    logic dv_x [0:MAXC-1];
    int   flag_ev[0:MAXC-1];
    logic obs_cnt[0:MAXC-1];
    logic obs_des[0:MAXC-1];
    logic obs_dv [0:MAXC-1];
    logic obs_pe [0:MAXC-1];
    logic obs_se [0:MAXC-1];

    int vectors = 0;
    int miscompares = 0;
    int exp_gl = 0, exp_pc = 0, exp_sc = 0;

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // One frame starting with RX_IN low in IDLE interval t0; counter edge 0 lands at t0+1.
    task automatic add_frame(input int t0, input int p, input bit pen, input bit gl,
                             input bit perr, input bit serr, input logic [7:0] d,
                             input int rst_at, output int last);
        int s, chk, k, e, ix, lim;
        bit pe_eff;
        s   = t0 + 1;
        chk = p / 2 + 2;
        k   = DW + 1 + (pen ? 1 : 0);
        for (int j = t0; j < MAXC; j++) pre_a[j] = p;
        pen_a[t0] = pen;
        if (gl) begin
            for (int j = 0; j < 3; j++) rx_a[t0 + j] = 1'b0;
            for (int j = s; j <= s + chk; j++) cnt_x[j] = 1'b1;
            sc_x[s + chk] = 1'b1;
            gl_a[s + chk] = 1'b1;
            if (exp_gl < 255) exp_gl++;
            last = s + chk;
            return;
        end
        for (int b = 0; b <= k; b++)
            for (int j = 0; j < p; j++) begin
                ix = t0 + b * p + j;
                if (b == 0)                  rx_a[ix] = 1'b0;
                else if (b <= DW)            rx_a[ix] = d[b-1];
                else if (pen && b == DW + 1) rx_a[ix] = ^d;
                else                         rx_a[ix] = 1'b1;
            end
        e      = s + k * p + chk + 1;
        pe_eff = pen && perr;
        lim    = (rst_at < 0) ? MAXC : rst_at;
        for (int j = s; j <= e && j <= lim; j++) cnt_x[j] = 1'b1;
        gl_a[s + chk] = 1'b0;
        if (s + chk <= lim) sc_x[s + chk] = 1'b1;
        for (int b = 1; b <= DW; b++)
            if (s + b * p + chk <= lim) des_x[s + b * p + chk] = 1'b1;
        if (pen) begin
            ix = s + (DW + 1) * p + chk;
            pe_a[ix] = perr;
            if (ix <= lim) pc_x[ix] = 1'b1;
        end
        ix = s + k * p + chk;
        se_a[ix] = serr;
        if (ix <= lim) tc_x[ix] = 1'b1;
        if (rst_at < 0) begin
            dv_x[e]    = !pe_eff && !serr;
            flag_ev[e] = (pe_eff ? 2 : 0) + (serr ? 1 : 0);
            if (pe_eff && exp_pc < 255) exp_pc++;
            if (serr && exp_sc < 255)   exp_sc++;
            last = e;
        end else begin
            rst_a[rst_at]       = 1'b1;
            rst_a[rst_at + 1]   = 1'b1;
            flag_ev[rst_at + 1] = 0;
            for (int j = rst_at; j <= t0 + (k + 1) * p; j++) rx_a[j] = 1'b1;
            exp_gl = 0; exp_pc = 0; exp_sc = 0;
            last = rst_at + 2;
        end
    endtask

    function automatic int count_des(input int a, input int b);
        int n = 0;
        for (int j = a; j <= b; j++) if (obs_des[j] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_dv(input int a, input int b);
        int n = 0;
        for (int j = a; j <= b; j++) if (obs_dv[j] === 1'b1) n++;
        return n;
    endfunction

    initial begin
        int t, e, ncyc, cur_fl, p, r;
        int t1, e1, t2, e2, tg, eg, t3, e3, t4, e4, t7, e7, t8, e8, t9, e9;
        logic [8:0] act, expv;

        for (int j = 0; j < MAXC; j++) begin
            rx_a[j] = 1'b1;  pen_a[j] = 1'($urandom_range(0, 1));
            gl_a[j] = 1'($urandom_range(0, 1));
            pe_a[j] = 1'($urandom_range(0, 1));
            se_a[j] = 1'($urandom_range(0, 1));
            rst_a[j] = 1'b0; pre_a[j] = PRESC_X8;
            cnt_x[j] = 1'b0; des_x[j] = 1'b0; sc_x[j] = 1'b0;
            pc_x[j] = 1'b0;  tc_x[j] = 1'b0;  dv_x[j] = 1'b0;
            flag_ev[j] = -1;
        end

        t1 = 4;       add_frame(t1, PRESC_X8, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, -1, e1);
        t2 = e1 + 10; add_frame(t2, PRESC_X16, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, -1, e2);
        tg = e2 + 8;  add_frame(tg, PRESC_X8, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, -1, eg);
        t3 = eg + 5;  add_frame(t3, PRESC_X32, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, -1, e3);
        t4 = e3 + 3;  add_frame(t4, PRESC_X32, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, -1, e4);
        t = e4 + 4;   r = t + 1 + 4 * PRESC_X8 + 3;
        add_frame(t, PRESC_X8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h96, r, e);
        t7 = e + 2;   add_frame(t7, PRESC_X8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, -1, e7);
        t8 = e7 + 6;  add_frame(t8, PRESC_X8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, -1, e8);
        t9 = (e8 - 1) + PRESC_X8 / 2;
        add_frame(t9, PRESC_X8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7E, -1, e9);

        t = e9 + 1;
        while (t < MAXC - 800) begin
            p = PRESC_X8 << $urandom_range(0, 2);
            add_frame(t, p, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      8'($urandom), -1, e);
            t = e + 1 + $urandom_range(0, 20);
        end
        ncyc = t + 10;

        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; prescale = PW'(PRESC_X8);
        strt_glitch = 1'b0; par_err_in = 1'b0; stp_err_in = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_state", int'({cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                                   stp_chk_en, data_valid, par_err, stp_err}), 0);
        @(negedge CLK);
        RST = 1'b0;

        cur_fl = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            if (flag_ev[c] >= 0) cur_fl = flag_ev[c];
            act  = {cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                    stp_chk_en, data_valid, par_err, stp_err};
            expv = {cnt_x[c], cnt_x[c], des_x[c], sc_x[c], pc_x[c], tc_x[c], dv_x[c],
                    (cur_fl >= 2), (cur_fl % 2 == 1)};
            obs_cnt[c] = cnt_en; obs_des[c] = deser_en; obs_dv[c] = data_valid;
            obs_pe[c]  = par_err; obs_se[c] = stp_err;
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL outputs cyc %0d {cnt,samp,deser,strt,par,stp,dv,perr,serr}: got %b expected %b",
                         c, act, expv);
            end
            RX_IN = rx_a[c]; PAR_EN = pen_a[c]; prescale = PW'(pre_a[c]);
            strt_glitch = gl_a[c]; par_err_in = pe_a[c]; stp_err_in = se_a[c];
            RST = rst_a[c];
            if (c > 0 && rst_a[c] && !rst_a[c-1]) begin
                #1;
                check("rst_immediate", int'({cnt_en, dat_samp_en, deser_en, strt_chk_en,
                                             par_chk_en, stp_chk_en, data_valid, par_err,
                                             stp_err}), 0);
            end
        end

        // Hand-computed anchors for the directed frames.
        check("f1_eval_index", e1, 84);
        check("f1_deser_count", count_des(t1, e1), 8);
        check("f1_first_deser", int'(obs_des[19]), 1);
        check("f1_dv_at_eval", int'(obs_dv[84]), 1);
        check("f1_dv_count", count_dv(t1, e1 + 5), 1);
        check("f1_flags", int'({obs_pe[84], obs_se[84]}), 0);
        check("f1_cnt_drop", int'(obs_cnt[85]), 0);
        check("f2_length", e2 - t2, 172);
        check("f2_par_err", int'(obs_pe[e2]), 1);
        check("f2_no_dv", count_dv(t2, e2 + 2), 0);
        check("glitch_length", eg - tg, 7);
        check("glitch_cnt_high", int'(obs_cnt[tg + 7]), 1);
        check("glitch_cnt_drop", int'(obs_cnt[tg + 8]), 0);
        check("glitch_no_deser", count_des(tg, tg + 10), 0);
        check("glitch_par_held", int'(obs_pe[tg + 8]), 1);
        check("f3_stp_err", int'(obs_se[e3]), 1);
        check("f3_no_dv", int'(obs_dv[e3]), 0);
        check("f4_stp_clear", int'(obs_se[e4]), 0);
        check("f4_dv", int'(obs_dv[e4]), 1);
        check("rst_cnt_low", int'(obs_cnt[r + 1]), 0);
        check("post_rst_dv", int'(obs_dv[e7]), 1);
        check("b2b_first_dv", int'(obs_dv[e8]), 1);
        check("b2b_second_dv", int'(obs_dv[e9]), 1);
        check("b2b_second_len", e9 - t9, 80);
`ifdef UART_RX_ERR_STATS_EN
        check("stats_glitch", int'(glitch_cnt), exp_gl);
        check("stats_par", int'(par_err_cnt), exp_pc);
        check("stats_stp", int'(stp_err_cnt), exp_sc);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
